bp_cfg_boot_sequencer: RTL and testbench



---
 rtl/bp_common_cfg_link_pkg.sv | 38 +++
 rtl/bp_cfg_credit_counter.sv | 49 ++++
 rtl/bp_cfg_boot_sequencer.sv | 113 +++++++++++
 tb/tb_bp_cfg_boot_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_cfg_link_pkg.sv
// Shared types for the tile config link: register addresses, boot FSM states
// and the write packet layout used by config masters and their checkers.
package bp_common_cfg_link_pkg;

    localparam int cfg_max_core_width_gp = 8;
    localparam int cfg_max_data_width_gp = 64;

    typedef enum logic [3:0] {
        e_cfg_freeze   = 4'h0,
        e_cfg_core_id  = 4'h1,
        e_cfg_cce_mode = 4'h2,
        e_cfg_npc      = 4'h3
    } bp_cfg_addr_e;

    typedef enum logic [3:0] {
        e_idle,
        e_freeze,
        e_core_id,
        e_cce_mode,
        e_npc,
        e_drain,
        e_unfreeze,
        e_final_drain,
        e_done
    } bp_cfg_state_e;

    typedef struct packed {
        logic [cfg_max_core_width_gp-1:0] core;
        bp_cfg_addr_e                     addr;
        logic [cfg_max_data_width_gp-1:0] data;
    } bp_cfg_pkt_s;

    function automatic logic is_send_state(input bp_cfg_state_e s);
        return (s == e_freeze) || (s == e_core_id) || (s == e_cce_mode)
            || (s == e_npc) || (s == e_unfreeze);
    endfunction

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Up/down credit counter for a config master: tracks unacked writes and
// latches a sticky flag when a return arrives with nothing outstanding.
module bp_cfg_credit_counter #(
    parameter int max_credits_p = 4,
    parameter int width_p       = $clog2(max_credits_p + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o,
    output logic underflow_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_credits_p);

    logic [width_p-1:0] count_q, count_d;
    logic               underflow_q, underflow_d;

    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        unique case ({inc_i, dec_i})
            2'b10: count_d = count_q + 1'b1;
            2'b01: begin
                // A return with nothing outstanding is flagged, never wrapped.
                if (count_q == '0) underflow_d = 1'b1;
                else               count_d     = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign full_o      = (count_q == max_lp);
    assign empty_o     = (count_q == '0);
    assign underflow_o = underflow_q;

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Post-reset boot sequencer: freezes and programs every core over the config
// link, waits for all writes to land, then unfreezes the cores and signals done.
module bp_cfg_boot_sequencer
    import bp_common_cfg_link_pkg::*;
#(
    parameter int          num_core_p       = 4,
    parameter int          max_credits_p    = 4,
    parameter int          cfg_data_width_p = 64,
    parameter logic [63:0] reset_pc_p       = 64'h8000_0000,
    parameter int          cce_mode_p       = 1,
    localparam int         core_width_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_width_lp-1:0]    cfg_core_o,
    output bp_cfg_addr_e                cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ack_i,
    output logic                        done_o,
    output logic                        err_o
);

    localparam logic [core_width_lp-1:0] last_core_lp = core_width_lp'(num_core_p - 1);

    bp_cfg_state_e            state_q, state_d;
    logic [core_width_lp-1:0] core_q, core_d;
    logic                     handshake;
    logic                     credits_full, credits_empty;

    bp_cfg_credit_counter #(
        .max_credits_p(max_credits_p)
    ) credits (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (handshake),
        .dec_i      (cfg_ack_i),
        .full_o     (credits_full),
        .empty_o    (credits_empty),
        .underflow_o(err_o)
    );

    always_comb begin
        state_d    = state_q;
        core_d     = core_q;
        cfg_addr_o = e_cfg_freeze;
        cfg_data_o = '0;
        // Payload depends only on state/core, so it holds while the link stalls.
        cfg_v_o    = is_send_state(state_q) && !credits_full;
        handshake  = cfg_v_o && cfg_ready_i;

        unique case (state_q)
            e_idle: state_d = e_freeze;
            e_freeze: begin
                cfg_data_o = cfg_data_width_p'(1);
                if (handshake) state_d = e_core_id;
            end
            e_core_id: begin
                cfg_addr_o = e_cfg_core_id;
                cfg_data_o = cfg_data_width_p'(core_q);
                if (handshake) state_d = e_cce_mode;
            end
            e_cce_mode: begin
                cfg_addr_o = e_cfg_cce_mode;
                cfg_data_o = cfg_data_width_p'(cce_mode_p);
                if (handshake) state_d = e_npc;
            end
            e_npc: begin
                cfg_addr_o = e_cfg_npc;
                cfg_data_o = cfg_data_width_p'(reset_pc_p);
                if (handshake) begin
                    if (core_q == last_core_lp) begin
                        core_d  = '0;
                        state_d = e_drain;
                    end else begin
                        core_d  = core_q + 1'b1;
                        state_d = e_freeze;
                    end
                end
            end
            // No core may be released until every programming write has landed.
            e_drain: if (credits_empty) state_d = e_unfreeze;
            e_unfreeze: begin
                if (handshake) begin
                    if (core_q == last_core_lp) begin
                        core_d  = '0;
                        state_d = e_final_drain;
                    end else begin
                        core_d  = core_q + 1'b1;
                    end
                end
            end
            e_final_drain: if (credits_empty) state_d = e_done;
            e_done: ;
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            core_q  <= '0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
        end
    end

    assign cfg_core_o = core_q;
    assign done_o     = (state_q == e_done);

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Randomized scoreboard bench for the boot sequencer: expected writes come from
// a list built from the programming order; an ack model tracks outstanding writes.
module tb_bp_cfg_boot_sequencer;
    import bp_common_cfg_link_pkg::*;

    localparam int          num_core_lp    = 4;
    localparam int          max_credits_lp = 4;
    localparam int          n_writes_lp    = 5 * num_core_lp;
    localparam logic [63:0] reset_pc_lp    = 64'h8000_0000;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         cfg_v_o;
    logic         cfg_ready_i = 1'b0;
    logic [1:0]   cfg_core_o;
    bp_cfg_addr_e cfg_addr_o;
    logic [63:0]  cfg_data_o;
    logic         cfg_ack_i = 1'b0;
    logic         done_o;
    logic         err_o;

    bp_cfg_boot_sequencer #(
        .num_core_p      (num_core_lp),
        .max_credits_p   (max_credits_lp),
        .cfg_data_width_p(64),
        .reset_pc_p      (reset_pc_lp),
        .cce_mode_p      (1)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .cfg_v_o    (cfg_v_o),
        .cfg_ready_i(cfg_ready_i),
        .cfg_core_o (cfg_core_o),
        .cfg_addr_o (cfg_addr_o),
        .cfg_data_o (cfg_data_o),
        .cfg_ack_i  (cfg_ack_i),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    bp_cfg_pkt_s exp_q[$];
    int          due_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hs_count = 0;
    int          model_out = 0;
    bit          exp_err = 0;
    bit          done_seen = 0;
    bit          unf_seen = 0;
    bit          stall_q = 0;
    bp_cfg_pkt_s stall_pkt;
    int          ready_pct = 100;
    int          ack_dly_min = 2;
    int          ack_dly_max = 2;
    int          hold_idx = -1;
    bit          ack_en = 1;
    int          ack_budget = 0;
    bit          stray_req = 0;
    int          hold_hs_cyc = 0;
    int          unf_hs_cyc = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Programming order: four registers per core, then one release per core.
    function automatic void load_expected();
        bp_cfg_pkt_s p;
        exp_q.delete();
        for (int c = 0; c < num_core_lp; c++) begin
            p.core = 8'(c);
            p.addr = e_cfg_freeze;   p.data = 64'd1;       exp_q.push_back(p);
            p.addr = e_cfg_core_id;  p.data = 64'(c);      exp_q.push_back(p);
            p.addr = e_cfg_cce_mode; p.data = 64'd1;       exp_q.push_back(p);
            p.addr = e_cfg_npc;      p.data = reset_pc_lp; exp_q.push_back(p);
        end
        for (int c = 0; c < num_core_lp; c++) begin
            p.core = 8'(c); p.addr = e_cfg_freeze; p.data = 64'd0;
            exp_q.push_back(p);
        end
    endfunction

    // Link-side driver: ready pattern and acks for accepted writes.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (reset_i) begin
                due_q.delete();
                cfg_ack_i = 1'b0;
            end else if (stray_req) begin
                cfg_ack_i = 1'b1;
                stray_req = 1'b0;
            end else if (due_q.size() > 0 && due_q[0] <= cyc && (ack_en || ack_budget > 0)) begin
                cfg_ack_i = 1'b1;
                void'(due_q.pop_front());
                if (!ack_en) ack_budget--;
            end else begin
                cfg_ack_i = 1'b0;
            end
            cfg_ready_i = ($urandom_range(99, 0) < ready_pct);
        end
    end

    // Monitor: pops the scoreboard on every handshake and tracks outstanding writes.
    always @(negedge clk) begin
        bp_cfg_pkt_s got, want;
        bit          hs;
        int          d;
        if (reset_i) begin
            model_out = 0; exp_err = 0; stall_q = 0;
            hs_count = 0; done_seen = 0; unf_seen = 0;
        end else begin
            got.core = 8'(cfg_core_o);
            got.addr = cfg_addr_o;
            got.data = cfg_data_o;
            check("err_o", err_o, exp_err);
            if (stall_q) begin
                check("stall_v", cfg_v_o, 1'b1);
                check("stall_pkt", got, stall_pkt);
            end
            if (model_out >= max_credits_lp) check("v_at_full", cfg_v_o, 1'b0);
            if (done_o && !done_seen) begin
                done_seen = 1;
                check("done_writes_left", exp_q.size(), 0);
                check("done_outstanding", model_out, 0);
            end
            hs = cfg_v_o && cfg_ready_i;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_write: got %0h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    check("write", got, want);
                end
                if (got.addr == e_cfg_npc && got.core == 8'(num_core_lp - 1)) hold_hs_cyc = cyc;
                if (got.addr == e_cfg_freeze && got.data == 64'd0 && !unf_seen) begin
                    unf_seen = 1;
                    unf_hs_cyc = cyc;
                    check("drain_barrier", model_out, 0);
                end
                d = (hs_count == hold_idx) ? 50 : int'($urandom_range(ack_dly_max, ack_dly_min));
                due_q.push_back(cyc + d);
                hs_count++;
            end
            if (cfg_ack_i && !hs && model_out == 0) exp_err = 1;
            model_out = model_out + (hs ? 1 : 0) - ((cfg_ack_i && model_out > 0) ? 1 : 0);
            stall_q   = cfg_v_o && !cfg_ready_i;
            stall_pkt = got;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_v", cfg_v_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        load_expected();
        reset_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (done_o) break;
        end
        check(name, done_o, 1'b1);
        check({name, "_writes"}, hs_count, n_writes_lp);
    endtask

    initial begin
        bit found;

        // Full-rate link, fixed ack latency, plus first-write latency.
        ready_pct = 100; ack_dly_min = 2; ack_dly_max = 2; ack_en = 1; hold_idx = -1;
        do_reset();
        check("lat_idle_v", cfg_v_o, 1'b0);
        @(posedge clk); #1;
        check("lat_first_v", cfg_v_o, 1'b1);
        wait_done("basic_done");
        $display("scenario basic: writes=%0d done=%0b", hs_count, done_o);

        // Withheld acks, same-cycle handshake+ack, stray ack.
        ack_en = 0;
        do_reset();
        repeat (30) @(posedge clk); #1;
        check("withheld_writes", hs_count, 4);
        check("withheld_v", cfg_v_o, 1'b0);
        ack_budget = 1;
        repeat (10) @(posedge clk); #1;
        check("one_ack_writes", hs_count, 5);
        check("one_ack_v", cfg_v_o, 1'b0);
        ready_pct = 0;
        repeat (2) @(posedge clk); #1;
        ack_budget = 1;
        repeat (5) @(posedge clk); #1;
        check("stalled_v", cfg_v_o, 1'b1);
        check("stalled_writes", hs_count, 5);
        ready_pct = 100; ack_budget = 1;
        repeat (10) @(posedge clk); #1;
        check("simul_writes", hs_count, 7);
        check("simul_v", cfg_v_o, 1'b0);
        ack_en = 1;
        wait_done("withheld_done");
        check("pre_stray_err", err_o, 1'b0);
        stray_req = 1;
        repeat (3) @(posedge clk); #1;
        check("stray_err", err_o, 1'b1);
        check("stray_done", done_o, 1'b1);
        $display("scenario withheld/stray: writes=%0d err=%0b", hs_count, err_o);

        // Random backpressure and ack latency.
        ready_pct = 30; ack_dly_min = 1; ack_dly_max = 6;
        do_reset();
        wait_done("bp_done");
        $display("scenario backpressure: writes=%0d done=%0b", hs_count, done_o);

        // Drain barrier: last core's npc ack held for 50 cycles.
        ready_pct = 100; ack_dly_min = 2; ack_dly_max = 2; hold_idx = 4 * num_core_lp - 1;
        do_reset();
        wait_done("barrier_done");
        check("barrier_gap", (unf_hs_cyc - hold_hs_cyc) > 50, 1'b1);
        hold_idx = -1;
        $display("scenario barrier: npc@%0d unfreeze@%0d", hold_hs_cyc, unf_hs_cyc);

        // Reset while core 2 is on its cce_mode write.
        do_reset();
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (cfg_v_o && cfg_core_o == 2'd2 && cfg_addr_o == e_cfg_cce_mode) begin
                found = 1;
                break;
            end
        end
        check("mid_found", found, 1'b1);
        reset_i = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_v", cfg_v_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_err", err_o, 1'b0);
        check("mid_rst_core", cfg_core_o, 2'd0);
        load_expected();
        repeat (2) @(posedge clk); #1;
        reset_i = 1'b0;
        wait_done("restart_done");
        $display("scenario mid-reset: writes=%0d done=%0b", hs_count, done_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
